// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage. Owns the program counter, presents it to a
// combinational word-indexed instruction memory and captures the returned word
// into the IF/ID pipeline register. Handles stalls, branch redirects, flushes
// and halts once the PC runs past the populated ROM.
//
// Ports
//   clk              system clock, rising edge
//   rst              synchronous active-high reset
//   stall_i          hold PC and IF/ID contents
//   flush_i          squash IF/ID contents (bubble)
//   branch_taken_i   redirect PC to branch_target_i
//   branch_target_i  redirect target (word index)
//   imem_pc_o        read address to instruction memory (the PC register)
//   imem_instr_i     instruction word for imem_pc_o, same cycle
//   if_id_instr_o    IF/ID instruction (0 when bubble)
//   if_id_pc_o       IF/ID PC of that instruction
//   if_id_pc_next_o  IF/ID PC + PC_STEP (link value)
//   if_id_valid_o    IF/ID holds a real instruction
//   halted_o         fetch stopped, PC out of range
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | fetching one word per cycle while PC is inside the ROM
// HALT  | PC ran out of range; only reset or an in-range branch leaves
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter int IMEM_DEPTH = 400,
   parameter int RESET_PC   = 0,
   parameter int PC_STEP    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   output logic [31:0] imem_pc_o,
   input  logic [31:0] imem_instr_i,
   output logic [31:0] if_id_instr_o,
   output logic [31:0] if_id_pc_o,
   output logic [31:0] if_id_pc_next_o,
   output logic        if_id_valid_o,
   output logic        halted_o
);

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);
   localparam logic [31:0] STEP_W  = 32'(PC_STEP);
   localparam logic [31:0] RST_PC  = 32'(RESET_PC);

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] instr_q, instr_nxt;
   logic [31:0] ipc_q, ipc_nxt;
   logic [31:0] ipcn_q, ipcn_nxt;
   logic        valid_q, valid_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= RUN;
         pc      <= RST_PC;
         instr_q <= '0;
         ipc_q   <= '0;
         ipcn_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         pc      <= pc_nxt;
         instr_q <= instr_nxt;
         ipc_q   <= ipc_nxt;
         ipcn_q  <= ipcn_nxt;
         valid_q <= valid_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      instr_nxt = instr_q;
      ipc_nxt   = ipc_q;
      ipcn_nxt  = ipcn_q;
      valid_nxt = valid_q;

      if (branch_taken_i) begin
         // Redirect wins over stall and flush; the wrong-path word is squashed.
         pc_nxt    = branch_target_i;
         valid_nxt = 1'b0;
         instr_nxt = '0;
         state_nxt = (branch_target_i < DEPTH_W) ? RUN : HALT;
      end else if (flush_i) begin
         // Bubble goes in even under a stall; PC holds either way.
         valid_nxt = 1'b0;
         instr_nxt = '0;
      end else if (stall_i) begin
         // hold everything
      end else if (state == RUN && pc < DEPTH_W) begin
         instr_nxt = imem_instr_i;
         ipc_nxt   = pc;
         ipcn_nxt  = pc + STEP_W;
         valid_nxt = 1'b1;
         pc_nxt    = pc + STEP_W;
      end else begin
         // Past the ROM (or already halted): never fetch, keep emitting bubbles.
         valid_nxt = 1'b0;
         instr_nxt = '0;
         state_nxt = HALT;
      end
   end

   assign imem_pc_o       = pc;
   assign if_id_instr_o   = instr_q;
   assign if_id_pc_o      = ipc_q;
   assign if_id_pc_next_o = ipcn_q;
   assign if_id_valid_o   = valid_q;
   assign halted_o        = (state == HALT);

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the pipelined processor.
- Owns the program counter and drives it as the read address to the combinational, word-indexed instruction memory.
- Captures the returned instruction into the IF/ID pipeline register.
- Handles hazard-unit stalls, branch redirects, flushes, and a halt when the PC runs past the populated ROM depth.

Parameters:
- IMEM_DEPTH, 400, number of instruction words; valid fetch addresses are 0..IMEM_DEPTH-1.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 1, PC increment per fetch; the memory is word-indexed, so 1 means the next instruction.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_i  in  1  hazard unit: hold PC and IF/ID contents.
- flush_i  in  1  squash the IF/ID contents (insert a bubble).
- branch_taken_i  in  1  EX stage resolved a taken branch or jump.
- branch_target_i  in  32  redirect target, word index.
- imem_pc_o  out  32  read address to instruction memory; equals the PC register.
- imem_instr_i  in  32  instruction word returned combinationally for imem_pc_o.
- if_id_instr_o  out  32  IF/ID instruction.
- if_id_pc_o  out  32  IF/ID PC of that instruction.
- if_id_pc_next_o  out  32  IF/ID PC+PC_STEP, used as the link value.
- if_id_valid_o  out  1  IF/ID holds a real instruction; 0 means bubble.
- halted_o  out  1  fetch stopped, PC out of range.

Behaviour:
- The block is a single clock domain; all registers update on the rising edge of clk.
- Reset (rst=1, synchronous, active-high; overrides all other inputs):
  - PC <= RESET_PC and FSM <= RUN.
  - if_id_instr_o <= 0, if_id_pc_o <= 0, if_id_pc_next_o <= 0.
  - if_id_valid_o <= 0, halted_o <= 0.
- imem_pc_o = PC at all times. The memory is combinational, so imem_instr_i is valid in the same cycle.
- The FSM has two states, RUN and HALT. halted_o = (state == HALT).
- Per-edge priority when not in reset:
  1. branch_taken_i=1:
     - PC <= branch_target_i and IF/ID valid <= 0 (the wrong-path instruction is squashed).
     - Applies even when stall_i or flush_i is high.
     - If branch_target_i < IMEM_DEPTH, state <= RUN; otherwise state <= HALT.
  2. flush_i=1 (no branch): IF/ID valid <= 0 and PC holds. If stall_i is also high, the stall still holds PC, but the bubble is still inserted.
  3. stall_i=1: PC and every IF/ID field hold their values, valid included.
  4. Normal, in RUN with PC < IMEM_DEPTH:
     - IF/ID instr <= imem_instr_i, pc <= PC, pc_next <= PC+PC_STEP, valid <= 1.
     - PC <= PC+PC_STEP.
  5. In RUN with PC >= IMEM_DEPTH:
     - No fetch; IF/ID valid <= 0 and state <= HALT.
     - PC holds, so imem is never indexed out of range by a sequential fetch.
  6. In HALT with no branch: PC holds and IF/ID valid <= 0 every cycle.
- The only exits from HALT are rst, or branch_taken_i with an in-range target.
- When IF/ID valid=0, if_id_instr_o <= 0 (NOP encoding), so downstream decode sees a NOP.
- Latency: an instruction at address A appears on if_id_* one edge after PC=A is presented, absent stall or flush.
- Throughput: one instruction per cycle.
- PC arithmetic is 32-bit unsigned and wraps modulo 2^32. Wrap is unreachable in practice because the halt at IMEM_DEPTH occurs first.
- The last valid word, IMEM_DEPTH-1, is fetched normally. The next cycle sees PC=IMEM_DEPTH and halts with no valid output.
- Reset asserted mid-stall, mid-branch or in HALT takes effect on that same edge; the first fetch after reset release is RESET_PC.

Test Plan:
- Reset, then 4 free-running cycles with ROM words 0..3 = 0xA0,0xA1,0xA2,0xA3 -> if_id_pc_o = 0,1,2,3 on successive edges; instr matches; valid=1 from the 1st post-reset edge; halted_o=0.
- stall_i=1 for 2 cycles at PC=5 -> imem_pc_o stays 5; IF/ID holds the PC=4 instruction; fetch of 5 resumes after stall_i drops with no instruction lost or duplicated.
- At PC=7, branch_taken_i=1 with target=20 while stall_i=1 -> next edge: PC=20, valid=0. The following edge: if_id_pc_o=20, valid=1.
- flush_i=1 for one cycle at PC=10 -> valid=0 and if_id_instr_o=0 for that edge; PC stays 10, then fetch continues at 10.
- Run from PC=397 with IMEM_DEPTH=400 -> 397, 398, 399 fetched valid; at PC=400 halted_o=1 and valid stays 0. A branch to target 2 leaves HALT and fetches 2. A branch to target 450 stays in HALT.
- Assert rst while in HALT and while stalled -> next edge: all outputs 0, PC=RESET_PC; the first valid fetch is address 0.
